// File: rtl/cmosnot_pkg.sv
// Shared constants for the cmosnot inverter slice: counter width default and reset values.
package cmosnot_pkg;

    localparam int          CNT_W_DEF = 8;
    localparam logic        OUT_Q_RST = 1'b1;
    localparam logic        IN_Q_RST  = 1'b0;
    localparam logic [15:0] CNT_RST   = 16'd0;

endpackage : cmosnot_pkg

// File: rtl/cmos_inv_cell.sv
// Transistor-level CMOS inverter: PMOS pull-up to supply, NMOS pull-down to ground.
module cmos_inv_cell (
    input  logic a,
    output wire  y
);

    supply1 vdd;
    supply0 gnd;

    // An unknown gate leaves both devices partially on, so y resolves to X.
    pmos p_up   (y, vdd, a);
    nmos n_down (y, gnd, a);

endmodule : cmos_inv_cell

// File: rtl/cmosnot.sv
// Inverter with a registered output and, when CMOSNOT_STATS_EN is defined,
// a saturating counter of input transitions sampled on clk.
module cmosnot
    import cmosnot_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    output logic             out,
    output logic             out_q
`ifdef CMOSNOT_STATS_EN
    ,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             edge_sat
`endif
);

    wire inv_y;

    cmos_inv_cell u_cell (
        .a (in),
        .y (inv_y)
    );

    assign out = inv_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= OUT_Q_RST;
        end else begin
            out_q <= inv_y;
        end
    end

`ifdef CMOSNOT_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic in_q;
    logic trans;

    // An unknown input makes this comparison unknown, which the if below treats as false.
    assign trans = (in != in_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q     <= IN_Q_RST;
            edge_cnt <= CNT_RST[CNT_W-1:0];
        end else begin
            in_q <= in;
            if (trans && (edge_cnt != CNT_MAX)) begin
                edge_cnt <= edge_cnt + 1'b1;
            end
        end
    end

    assign edge_sat = (edge_cnt == CNT_MAX);
`endif

endmodule : cmosnot

// File: tb/tb_cmosnot.sv
// Bench for cmosnot: directed reset/boundary cases followed by random input toggling
// with occasional asynchronous resets, checked against a transition-counting model.
module tb_cmosnot;

    localparam int CW  = 3;
    localparam int SAT = (1 << CW) - 1;

    logic clk;
    logic rst;
    logic in;
    logic out;
    logic out_q;
`ifdef CMOSNOT_STATS_EN
    logic [CW-1:0] edge_cnt;
    logic          edge_sat;
`endif

    int checks   = 0;
    int failures = 0;

    // reference model state
    int   m_trans;
    logic m_last;
    logic m_out_q;

    cmosnot #(.CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in),
        .out      (out),
        .out_q    (out_q)
`ifdef CMOSNOT_STATS_EN
        ,
        .edge_cnt (edge_cnt),
        .edge_sat (edge_sat)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_cnt();
        return (m_trans > SAT) ? SAT : m_trans;
    endfunction

    task automatic model_reset();
        m_trans = 0;
        m_last  = 1'b0;
        m_out_q = 1'b1;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out"}, {31'd0, out}, {31'd0, ~in});
        check({tag, ".out_q"}, {31'd0, out_q}, {31'd0, m_out_q});
`ifdef CMOSNOT_STATS_EN
        check({tag, ".edge_cnt"}, {{(32-CW){1'b0}}, edge_cnt}, exp_cnt());
        check({tag, ".edge_sat"}, {31'd0, edge_sat}, {31'd0, (exp_cnt() == SAT)});
`endif
    endtask

    // One rising edge: the model samples in, then outputs are checked 1 ns later.
    task automatic tick(input string tag);
        @(posedge clk);
        if (!rst) begin
            if (!$isunknown(in) && !$isunknown(m_last) && (in != m_last))
                m_trans++;
            m_last  = in;
            m_out_q = ~in;
        end
        #1;
        check_all(tag);
    endtask

    task automatic async_reset_pulse(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in  = 1'b0;
        model_reset();
        #1;
        check_all("reset_state");

        // zero-latency inverter behaviour, independent of reset
        in = 1'b0;
        #1 check("comb_in0", {31'd0, out}, 32'd1);
        #4 in = 1'b1;
        #1 check("comb_in1", {31'd0, out}, 32'd0);

        // reset held with clock running and input toggling
        for (int i = 0; i < 4; i++) begin
            in = ~in;
            tick("rst_hold");
        end

        in  = 1'b0;
        rst = 1'b0;
        tick("post_rst_idle");

        // three consecutive toggles, the first against the reset value of in_q
        in = 1'b1; tick("toggle1");
        in = 1'b0; tick("toggle2");
        in = 1'b1; tick("toggle3");
`ifdef CMOSNOT_STATS_EN
        check("three_toggles", {{(32-CW){1'b0}}, edge_cnt}, 32'd3);
`endif

        // push past saturation
        for (int i = 0; i < SAT + 3; i++) begin
            in = ~in;
            tick("saturate");
        end
`ifdef CMOSNOT_STATS_EN
        check("sat_flag", {31'd0, edge_sat}, 32'd1);
`endif
        in = ~in;
        async_reset_pulse("rst_from_sat");

        // unknown input: only meaningful on a four-state simulator
        in = 1'bz;
        #1;
        if ($isunknown(in)) begin
            check("z_out", {31'd0, out}, {31'd0, 1'bx});
            tick("z_edge");
            in = 1'b1;
            tick("after_z");
            async_reset_pulse("rst_after_z");
        end else begin
            in = 1'b0;
        end

        // random toggling with occasional asynchronous reset
        for (int i = 0; i < 300; i++) begin
            in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0)
                async_reset_pulse("rand_rst");
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cmosnot

// File: doc/cmosnot.md
CMOSNOT -- requirements
Module: cmosnot

Interface
REQ-001 Parameter CNT_W, default 8, width of the input-transition counter (legal range 2..16).
REQ-002 Port clk  input  1  single clock; all sequential logic samples on its rising edge.
REQ-003 Port rst  input  1  reset; asynchronous, active-high; one clock domain (clk), no other clock.
REQ-004 Port in  input  1  inverter input.
REQ-005 Port out  output  1  combinational inverter output.
REQ-006 Port out_q  output  1  registered copy of out.
REQ-007 Port edge_cnt  output  CNT_W  saturating count of input transitions (present only with CMOSNOT_STATS_EN).
REQ-008 Port edge_sat  output  1  high while edge_cnt is at all-ones (present only with CMOSNOT_STATS_EN).

Function
REQ-009 out SHALL equal NOT in with zero clock latency, driven through a complementary pull-up/pull-down transistor pair (PMOS to supply, NMOS to ground).
REQ-010 out SHALL be independent of clk and rst, so it is correct even when clk/rst are left unconnected.
REQ-011 in = 0 SHALL give out = 1; in = 1 SHALL give out = 0; in = X or Z SHALL give out = X (no silent resolution).
REQ-012 out_q SHALL load NOT in on every rising clk edge, i.e. one cycle of latency behind out.
REQ-013 A transition is a change of in between consecutive rising clk edges, detected against an internal registered copy in_q.
REQ-014 edge_cnt SHALL increment by 1 on each detected transition and hold otherwise.
REQ-015 edge_cnt SHALL saturate at 2^CNT_W-1 and not wrap; edge_sat SHALL be high exactly while edge_cnt is all-ones.
REQ-016 An X/Z on in at a sampling edge SHALL NOT count as a transition.

Reset
REQ-017 While rst is high: out_q = 1, in_q = 0, edge_cnt = 0, edge_sat = 0, asynchronously, regardless of clk.
REQ-018 Reset asserted mid-operation SHALL clear the counter immediately, including from saturation; out keeps tracking in throughout.
REQ-019 After rst falls, the first rising edge compares in against in_q = 0, so in = 1 at that edge counts one transition.

Configuration
REQ-020 Macro CMOSNOT_STATS_EN defined: in_q, edge_cnt and edge_sat logic and ports SHALL be compiled in.
REQ-021 Macro CMOSNOT_STATS_EN undefined: those ports and registers SHALL be absent; out and out_q behave identically.

Structure
REQ-022 Package cmosnot_pkg SHALL hold the CNT_W default constant and the reset-value constants (OUT_Q_RST = 1, CNT_RST = 0).
REQ-023 Sub-module cmos_inv_cell SHALL contain only the transistor-level inverter (ports a, y); cmosnot instantiates it once and adds the registers around it.

Verification
REQ-024 in = 0 held 5 ns, then in = 1 held 5 ns -> out = 1 then out = 0, each with zero delay after the input change.
REQ-025 rst = 1 with clk running, in toggling -> out_q = 1, edge_cnt = 0 throughout; out still follows NOT in.
REQ-026 After reset, in toggles on 3 consecutive edges -> edge_cnt = 3 and out_q = NOT in one cycle later.
REQ-027 CNT_W = 2, 5 transitions -> edge_cnt = 3, edge_sat = 1; assert rst -> edge_cnt = 0 immediately, edge_sat = 0.
REQ-028 in = Z -> out = X; edge_cnt unchanged at the next edge.
REQ-029 Build without CMOSNOT_STATS_EN, repeat REQ-024 stimulus -> identical out and out_q waveforms.
